// File: rtl/read_ptr_ctrl.sv
// Read-side pointer controller for a power-of-two FIFO: read pointer, empty/occupancy and dequeue port.
// Define READ_PTR_CTRL_PREFETCH_EN to add a registered output stage; the default build exposes storage data directly.
module read_ptr_ctrl #(
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = $clog2(DEPTH) + 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PTR_WIDTH-1:0]  w_ptr,
    output logic [PTR_WIDTH-1:0]  r_ptr,
    output logic                  empty,
    output logic [PTR_WIDTH-2:0]  raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  deq_val,
    input  logic                  deq_rdy,
    output logic [DATA_WIDTH-1:0] deq_msg,
    output logic [PTR_WIDTH-1:0]  count
);

    logic [PTR_WIDTH-1:0] r_ptr_q;
    logic [PTR_WIDTH-1:0] r_ptr_d;
    logic                 pop;

    // Wrap bit makes equal pointers mean empty and a difference of DEPTH mean full.
    assign empty = (w_ptr == r_ptr_q);
    assign count = w_ptr - r_ptr_q;
    assign raddr = r_ptr_q[PTR_WIDTH-2:0];
    assign r_ptr = r_ptr_q;

    // Read pointer next-state: advance by one on every pop.
    always_comb begin
        r_ptr_d = r_ptr_q;
        if (pop) begin
            r_ptr_d = r_ptr_q + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_ptr_d = r_ptr_q;
        end
    end

    // Read pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= r_ptr_d;
        end
    end

`ifdef READ_PTR_CTRL_PREFETCH_EN
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] msg_q;
    logic [DATA_WIDTH-1:0] msg_d;
    logic                  xfer;

    // Output-register FSM: refill whenever the register is free or being drained this cycle.
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        xfer    = (state_q == HOLD) & deq_rdy;
        pop     = ~empty & ((state_q == IDLE) | xfer);
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (xfer & ~pop) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            msg_d = rdata;
        end else begin
            msg_d = msg_q;
        end
    end

    // Output register and FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
        end
    end

    assign deq_val = (state_q == HOLD);
    assign deq_msg = msg_q;
`else
    assign deq_val = ~empty;
    assign deq_msg = rdata;
    assign pop     = deq_val & deq_rdy;
`endif

endmodule

// File: tb/tb_read_ptr_ctrl.sv
// Randomized bench for read_ptr_ctrl against a queue-based FIFO reference model; works with or without
// READ_PTR_CTRL_PREFETCH_EN.
module tb_read_ptr_ctrl;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] w_ptr;
    logic [PW-1:0] r_ptr;
    logic          empty;
    logic [PW-2:0] raddr;
    logic [DW-1:0] rdata;
    logic          deq_val;
    logic          deq_rdy;
    logic [DW-1:0] deq_msg;
    logic [PW-1:0] count;

    logic [DW-1:0] mem [DEPTH];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: messages resident in storage, pops so far, output register.
    logic [DW-1:0] q [$];
    int unsigned   rd_cnt;
    bit            outv_m;
    logic [DW-1:0] msg_m;

    read_ptr_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .w_ptr   (w_ptr),
        .r_ptr   (r_ptr),
        .empty   (empty),
        .raddr   (raddr),
        .rdata   (rdata),
        .deq_val (deq_val),
        .deq_rdy (deq_rdy),
        .deq_msg (deq_msg),
        .count   (count)
    );

    assign rdata = mem[raddr];

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("empty", 32'(empty), 32'(q.size() == 0));
        check_eq("count", 32'(count), 32'(q.size()));
        check_eq("r_ptr", 32'(r_ptr), rd_cnt % (2 ** PW));
        check_eq("raddr", 32'(raddr), rd_cnt % DEPTH);
`ifdef READ_PTR_CTRL_PREFETCH_EN
        check_eq("deq_val", 32'(deq_val), 32'(outv_m));
        check_eq("deq_msg", 32'(deq_msg), 32'(msg_m));
`else
        check_eq("deq_val", 32'(deq_val), 32'(q.size() != 0));
        if (q.size() != 0) check_eq("deq_msg", 32'(deq_msg), 32'(q[0]));
`endif
    endtask

    task automatic model_step(input bit rdy);
`ifdef READ_PTR_CTRL_PREFETCH_EN
        bit xfer;
        bit pop;
        xfer = outv_m && rdy;
        pop  = (q.size() != 0) && (!outv_m || xfer);
        if (pop) begin
            msg_m  = q.pop_front();
            outv_m = 1'b1;
            rd_cnt++;
        end else if (xfer) begin
            outv_m = 1'b0;
        end
`else
        if (q.size() != 0 && rdy) begin
            void'(q.pop_front());
            rd_cnt++;
        end
`endif
    endtask

    // One cycle: optional write (pw% chance), ready with pr% chance, check, advance model.
    task automatic cycle(input int pw, input int pr);
        logic [DW-1:0] d;
        @(negedge clk);
        rst = 1'b0;
        if ($urandom_range(99) < pw && q.size() < DEPTH) begin
            d = DW'($urandom);
            mem[w_ptr[PW-2:0]] = d;
            w_ptr = w_ptr + 1'b1;
            q.push_back(d);
        end
        deq_rdy = ($urandom_range(99) < pr);
        #1;
        check_all();
        model_step(deq_rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        w_ptr   = '0;
        deq_rdy = 1'($urandom);
        @(posedge clk);
        q.delete();
        rd_cnt = 0;
        outv_m = 1'b0;
        msg_m  = '0;
        #1;
        check_eq("rst_r_ptr", 32'(r_ptr), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_count", 32'(count), 32'd0);
`ifdef READ_PTR_CTRL_PREFETCH_EN
        check_eq("rst_deq_val", 32'(deq_val), 32'd0);
        check_eq("rst_deq_msg", 32'(deq_msg), 32'd0);
`else
        check_eq("rst_deq_val", 32'(deq_val), 32'd0);
`endif
    endtask

    initial begin
        rst     = 1'b1;
        w_ptr   = '0;
        deq_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        do_reset();
        // Single write with consumer stalled: message must be held steady.
        cycle(100, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0);
        // Fill to full, then drain at one per cycle.
        for (int i = 0; i < 8; i++) cycle(100, 0);
        for (int i = 0; i < 8; i++) cycle(0, 100);
        // Streaming across several pointer wraps.
        for (int i = 0; i < 40; i++) cycle(100, 100);
        // Randomized traffic with occasional mid-operation resets.
        for (int blk = 0; blk < 12; blk++) begin
            int pw;
            int pr;
            pw = $urandom_range(10, 100);
            pr = $urandom_range(10, 100);
            for (int i = 0; i < 250; i++) cycle(pw, pr);
            do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
